// File: rtl/kd_ntt_pkg.sv
// Shared definitions for the Kyber/Dilithium NTT butterfly sequencer:
// FSM encoding, scheme selectors, done_flag bit positions and the
// layer-count helper.
package kd_ntt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } kd_state_t;

    // kd_mode values
    localparam logic KYBER     = 1'b0;
    localparam logic DILITHIUM = 1'b1;

    // done_flag bit positions
    localparam int DONE_NTT  = 0;
    localparam int DONE_INTT = 1;

    // Kyber stops one layer early (len = 2), Dilithium runs all LOGN layers.
    function automatic int layer_count(input int logn, input logic kd);
        return (kd == DILITHIUM) ? logn : logn - 1;
    endfunction

endpackage

// File: rtl/kd_ntt_seq_delay_line.sv
// kd_delay_line: DEPTH-stage shift register with a global freeze.
// Carries the read strobe and read addresses forward to become the
// write-back strobe and addresses once the butterfly result is ready.
module kd_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             freeze,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
        logic [WIDTH-1:0] q_reg;
        if (gi == 0) begin : g_head
            // First stage captures the live read side.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst)
                    q_reg <= '0;
                else if (!freeze)
                    q_reg <= din;
            end
        end else begin : g_tail
            // Later stages shift the previous stage along.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst)
                    q_reg <= '0;
                else if (!freeze)
                    q_reg <= g_stage[gi-1].q_reg;
            end
        end
    end

    assign dout = g_stage[DEPTH-1].q_reg;

endmodule

// File: rtl/kd_ntt_seq.sv
// kd_ntt_seq: generic NTT / INTT butterfly scheduler for the unified
// Kyber/Dilithium core. Issues one butterfly per cycle per layer, drains
// the butterfly pipeline between layers and replays read addresses as
// write-backs PIPE_LAT cycles later.
// Optional build macro: KD_SEQ_HOLD_EN adds a 'hold' input that freezes
// the whole schedule (counters and delay line) while high.
module kd_ntt_seq
    import kd_ntt_pkg::*;
#(
    parameter int LOGN     = 8,
    parameter int PIPE_LAT = 5,
    parameter int TWW      = LOGN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            kd_mode,
    input  logic            inv,
`ifdef KD_SEQ_HOLD_EN
    input  logic            hold,
`endif
    output logic            rd_en,
    output logic [LOGN-1:0] rd_addr_a,
    output logic [LOGN-1:0] rd_addr_b,
    output logic [TWW-1:0]  tw_addr,
    output logic            bf_mode0,
    output logic            bf_mode1,
    output logic            wr_en,
    output logic [LOGN-1:0] wr_addr_a,
    output logic [LOGN-1:0] wr_addr_b,
    output logic            busy,
    output logic [1:0]      done_flag
);

    localparam int JW = LOGN - 1;                               // butterfly index width
    localparam int LW = $clog2(LOGN + 1);                       // layer / shift width
    localparam int CW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;  // drain counter width
    localparam int DW = 1 + 2 * LOGN;                           // delay line payload

    logic hold_w;
`ifdef KD_SEQ_HOLD_EN
    assign hold_w = hold;
`else
    assign hold_w = 1'b0;
`endif

    kd_state_t       state_reg, state_next;
    logic [JW-1:0]   j_reg, j_next;
    logic [LW-1:0]   layer_reg, layer_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic            kd_reg, kd_next;
    logic            inv_reg, inv_next;
    logic            busy_reg, busy_next;
    logic [1:0]      done_reg, done_next;
    logic [LW-1:0]   last_layer;

    assign last_layer = LW'(layer_count(LOGN, kd_reg) - 1);

    // State and schedule counters; reset aborts any run immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
            j_reg     <= '0;
            layer_reg <= '0;
            cnt_reg   <= '0;
            kd_reg    <= 1'b0;
            inv_reg   <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 2'b00;
        end else begin
            state_reg <= state_next;
            j_reg     <= j_next;
            layer_reg <= layer_next;
            cnt_reg   <= cnt_next;
            kd_reg    <= kd_next;
            inv_reg   <= inv_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
        end
    end

    // Next-state: issue N/2 butterflies, drain PIPE_LAT cycles, repeat per layer.
    always_comb begin
        state_next = state_reg;
        j_next     = j_reg;
        layer_next = layer_reg;
        cnt_next   = cnt_reg;
        kd_next    = kd_reg;
        inv_next   = inv_reg;
        busy_next  = busy_reg;
        done_next  = done_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_ISSUE;
                    j_next     = '0;
                    layer_next = '0;
                    cnt_next   = '0;
                    kd_next    = kd_mode;
                    inv_next   = inv;
                    busy_next  = 1'b1;
                    done_next  = 2'b00;
                end
            end
            ST_ISSUE: begin
                if (!hold_w) begin
                    if (j_reg == {JW{1'b1}}) begin
                        state_next = ST_DRAIN;
                        cnt_next   = '0;
                    end else begin
                        j_next = j_reg + JW'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if (!hold_w) begin
                    if (cnt_reg == CW'(PIPE_LAT - 1)) begin
                        j_next = '0;
                        if (layer_reg == last_layer) begin
                            state_next = ST_DONE;
                            busy_next  = 1'b0;
                            done_next[inv_reg ? DONE_INTT : DONE_NTT] = 1'b1;
                        end else begin
                            state_next = ST_ISSUE;
                            layer_next = layer_reg + LW'(1);
                        end
                    end else begin
                        cnt_next = cnt_reg + CW'(1);
                    end
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Butterfly address generation. len is always a power of two, so
    // grp/k are a shift and a mask; everything wraps modulo 2^LOGN, which
    // also makes the inverse twiddle 2G-1-grp correct when 2G == N.
    logic [LW-1:0]   sh;
    logic [LOGN-1:0] jx, len_v, grp, k_off, a_calc, b_calc, tw_calc;
    always_comb begin
        if (inv_reg)
            sh = (kd_reg == KYBER) ? layer_reg + LW'(1) : layer_reg;
        else
            sh = LW'(LOGN - 1) - layer_reg;
        jx     = LOGN'(j_reg);
        len_v  = LOGN'(1) << sh;
        grp    = jx >> sh;
        k_off  = jx & (len_v - LOGN'(1));
        a_calc = (grp << (sh + LW'(1))) | k_off;
        b_calc = a_calc | len_v;
        if (inv_reg)
            tw_calc = (LOGN'(1) << (LW'(LOGN) - sh)) - LOGN'(1) - grp;
        else
            tw_calc = (LOGN'(1) << layer_reg) + grp;
    end

    logic issue_st;
    assign issue_st  = (state_reg == ST_ISSUE);
    assign rd_en     = issue_st && !hold_w;
    assign rd_addr_a = issue_st ? a_calc : '0;
    assign rd_addr_b = issue_st ? b_calc : '0;
    assign tw_addr   = issue_st ? TWW'(tw_calc) : '0;
    assign bf_mode0  = kd_reg;
    assign bf_mode1  = inv_reg;
    assign busy      = busy_reg;
    assign done_flag = done_reg;

    logic [DW-1:0] dl_out;

    kd_delay_line #(
        .WIDTH (DW),
        .DEPTH (PIPE_LAT)
    ) u_delay (
        .clk    (clk),
        .rst    (rst),
        .freeze (hold_w),
        .din    ({rd_en, rd_addr_a, rd_addr_b}),
        .dout   (dl_out)
    );

    assign wr_en     = dl_out[2*LOGN] && !hold_w;
    assign wr_addr_a = dl_out[2*LOGN-1:LOGN];
    assign wr_addr_b = dl_out[LOGN-1:0];

endmodule

// File: tb/tb_kd_ntt_seq.sv
// Self-checking bench for kd_ntt_seq (LOGN=8, PIPE_LAT=5). A schedule model
// built from the transform formulas predicts every output on every cycle.
`timescale 1ns/1ps
module tb_kd_ntt_seq;

    localparam int LOGN = 8;
    localparam int N    = 256;
    localparam int P    = 5;
    localparam int HALF = N / 2;
    localparam int PER  = HALF + P;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       kd_mode = 1'b0;
    logic       inv = 1'b0;
    logic       hold = 1'b0;
    logic       rd_en, bf_mode0, bf_mode1, wr_en, busy;
    logic [7:0] rd_addr_a, rd_addr_b, tw_addr, wr_addr_a, wr_addr_b;
    logic [1:0] done_flag;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    kd_ntt_seq #(.LOGN(8), .PIPE_LAT(5), .TWW(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .kd_mode   (kd_mode),
        .inv       (inv),
`ifdef KD_SEQ_HOLD_EN
        .hold      (hold),
`endif
        .rd_en     (rd_en),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .tw_addr   (tw_addr),
        .bf_mode0  (bf_mode0),
        .bf_mode1  (bf_mode1),
        .wr_en     (wr_en),
        .wr_addr_a (wr_addr_a),
        .wr_addr_b (wr_addr_b),
        .busy      (busy),
        .done_flag (done_flag)
    );

    // Butterfly issued at issue-cycle c of a run (c = 0 is the cycle after accept).
    function automatic void mdl_rd(input int c, input int kd, input int iv,
                                   output int en, output int a, output int b, output int tw);
        int layers, s, j, len, grp, k;
        layers = LOGN - 1 + kd;
        en = 0; a = 0; b = 0; tw = 0;
        if (c >= 0 && c < layers * PER && (c % PER) < HALF) begin
            s = c / PER;
            j = c % PER;
            if (iv != 0) len = 1 << (s + 1 - kd);
            else         len = N >> (s + 1);
            grp = j / len;
            k   = j % len;
            a   = 2 * len * grp + k;
            b   = a + len;
            if (iv != 0) tw = 2 * (N / (2 * len)) - 1 - grp;
            else         tw = (1 << s) + grp;
            en = 1;
        end
    endfunction

    task automatic chk(input string name, input int got, input int want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Model state: whether a run is known, its progress (held cycles do not count).
    bit m_run = 1'b0;
    int m_c   = 0;
    int m_kd  = 0;
    int m_inv = 0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_run <= 1'b0;
            m_c   <= 0;
            m_kd  <= 0;
            m_inv <= 0;
        end else if (!m_run || m_c > (LOGN - 1 + m_kd) * PER) begin
            if (start) begin
                m_run <= 1'b1;
                m_c   <= 0;
                m_kd  <= int'(kd_mode);
                m_inv <= int'(inv);
            end else begin
                m_c <= m_c + 1;
            end
        end else if (!(hold && m_c < (LOGN - 1 + m_kd) * PER)) begin
            m_c <= m_c + 1;
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin : cmp
        logic [46:0] exp_v, act_v;
        int layers, e, a, b, tw, we, wa, wb, wt;
        bit held;
        if (chk_en) begin
            if (!m_run) begin
                exp_v = '0;
            end else begin
                layers = LOGN - 1 + m_kd;
                held = hold && (m_c < layers * PER);
                mdl_rd(m_c, m_kd, m_inv, e, a, b, tw);
                mdl_rd(m_c - P, m_kd, m_inv, we, wa, wb, wt);
                exp_v = {1'((e != 0) && !held), 8'(a), 8'(b), 8'(tw), 1'(m_kd), 1'(m_inv),
                         1'((we != 0) && !held), 8'(wa), 8'(wb), 1'(m_c < layers * PER),
                         (m_c >= layers * PER) ? ((m_inv != 0) ? 2'b10 : 2'b01) : 2'b00};
            end
            act_v = {rd_en, rd_addr_a, rd_addr_b, tw_addr, bf_mode0, bf_mode1,
                     wr_en, wr_addr_a, wr_addr_b, busy, done_flag};
            total++;
            if (act_v !== exp_v) begin
                bad++;
                $display("FAIL cycle_chk t=%0t c=%0d got=%h want=%h", $time, m_c, act_v, exp_v);
            end
        end
    end

    // Read statistics and read-before-write hazard tracking per run.
    int rd_cnt = 0, hazards = 0;
    int first_a, first_b, first_tw, last_a, last_b, last_tw;
    int pending [N];

    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            pending[wr_addr_a] = pending[wr_addr_a] - 1;
            pending[wr_addr_b] = pending[wr_addr_b] - 1;
        end
        if (rd_en === 1'b1) begin
            if (pending[rd_addr_a] != 0 || pending[rd_addr_b] != 0) hazards++;
            pending[rd_addr_a] = pending[rd_addr_a] + 1;
            pending[rd_addr_b] = pending[rd_addr_b] + 1;
            if (rd_cnt == 0) begin
                first_a = rd_addr_a; first_b = rd_addr_b; first_tw = tw_addr;
            end
            last_a = rd_addr_a; last_b = rd_addr_b; last_tw = tw_addr;
            rd_cnt++;
        end
    end

    task automatic do_run(input bit kd, input bit iv, input int hold_at, input int hold_len,
                          output int cyc);
        logic [7:0] frz;
        rd_cnt = 0;
        hazards = 0;
        for (int i = 0; i < N; i++) pending[i] = 0;
        kd_mode = kd;
        inv = iv;
        start = 1'b1;
        step();
        start = 1'b0;
        cyc = 0;
        frz = '0;
        while (done_flag == 2'b00 && cyc < 3000) begin
            if (hold_len > 0 && cyc == hold_at) begin
                hold = 1'b1;
                #1 frz = rd_addr_a;
            end
            if (hold_len > 0 && cyc == hold_at + hold_len - 1) begin
                chk("hold_addr_frozen", int'(rd_addr_a), int'(frz));
                chk("hold_rd_en_low", int'(rd_en), 0);
            end
            if (hold_len > 0 && cyc == hold_at + hold_len) hold = 1'b0;
            step();
            cyc++;
        end
        if (cyc >= 3000) begin
            total++;
            bad++;
            $display("FAIL done_timeout got=%0d cycles want=done_flag set", cyc);
        end
        repeat (3) step();
    endtask

    initial begin
        int cyc, e, a, b, tw;
        rst = 1'b0;
        repeat (2) step();
        chk("reset_outputs_lo", int'({rd_addr_a, rd_addr_b, tw_addr, rd_en, wr_en, busy, done_flag}), 0);
        chk("reset_outputs_hi", int'({wr_addr_a, wr_addr_b, bf_mode0, bf_mode1}), 0);
        chk_en = 1'b1;
        rst = 1'b1;
        step();

        // Hand-computed points that pin the schedule model.
        mdl_rd(0, 1, 0, e, a, b, tw);
        chk("mdl_dil_ntt_first", a * 65536 + b * 256 + tw, 0 * 65536 + 128 * 256 + 1);
        mdl_rd(7 * PER + 127, 1, 0, e, a, b, tw);
        chk("mdl_dil_ntt_last", a * 65536 + b * 256 + tw, 254 * 65536 + 255 * 256 + 255);
        mdl_rd(6 * PER + 127, 0, 0, e, a, b, tw);
        chk("mdl_kyb_ntt_last", a * 65536 + b * 256 + tw, 253 * 65536 + 255 * 256 + 127);
        mdl_rd(130, 1, 0, e, a, b, tw);
        chk("mdl_drain_idle", e, 0);

        // Dilithium NTT
        do_run(1'b1, 1'b0, -1, 0, cyc);
        chk("dil_ntt_cycles", cyc, 1064);
        chk("dil_ntt_rd_count", rd_cnt, 1024);
        chk("dil_ntt_first", first_a * 65536 + first_b * 256 + first_tw, 128 * 256 + 1);
        chk("dil_ntt_last", last_a * 65536 + last_b * 256 + last_tw, 254 * 65536 + 255 * 256 + 255);
        chk("dil_ntt_done", int'(done_flag), 1);
        chk("dil_ntt_hazards", hazards, 0);

        // Kyber NTT
        do_run(1'b0, 1'b0, -1, 0, cyc);
        chk("kyb_ntt_cycles", cyc, 931);
        chk("kyb_ntt_rd_count", rd_cnt, 896);
        chk("kyb_ntt_last", last_a * 65536 + last_b * 256 + last_tw, 253 * 65536 + 255 * 256 + 127);
        chk("kyb_ntt_done", int'(done_flag), 1);

        // Dilithium INTT
        do_run(1'b1, 1'b1, -1, 0, cyc);
        chk("dil_intt_cycles", cyc, 1064);
        chk("dil_intt_first", first_a * 65536 + first_b * 256 + first_tw, 0 * 65536 + 1 * 256 + 255);
        chk("dil_intt_last", last_a * 65536 + last_b * 256 + last_tw, 127 * 65536 + 255 * 256 + 1);
        chk("dil_intt_done", int'(done_flag), 2);
        chk("dil_intt_hazards", hazards, 0);

        // Kyber INTT: starts at len = 2
        do_run(1'b0, 1'b1, -1, 0, cyc);
        chk("kyb_intt_cycles", cyc, 931);
        chk("kyb_intt_first", first_a * 65536 + first_b * 256 + first_tw, 0 * 65536 + 2 * 256 + 127);
        chk("kyb_intt_done", int'(done_flag), 2);

        // Ignored mid-run start, then reset at cycle 300
        kd_mode = 1'b1;
        inv = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (100) step();
        kd_mode = 1'b0;
        inv = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (198) step();
        chk("midrun_busy", int'(busy), 1);
        chk("midrun_mode_kept", int'({bf_mode0, bf_mode1}), 2);
        rst = 1'b0;
        #1;
        chk("abort_outputs_lo", int'({rd_addr_a, rd_addr_b, tw_addr, rd_en, wr_en, busy, done_flag}), 0);
        chk("abort_outputs_hi", int'({wr_addr_a, wr_addr_b, bf_mode0, bf_mode1}), 0);
        for (int i = 0; i < 6; i++) begin
            step();
            chk("abort_no_wr", int'(wr_en), 0);
        end
        rst = 1'b1;
        step();
        do_run(1'b0, 1'b0, -1, 0, cyc);
        chk("post_rst_cycles", cyc, 931);
        chk("post_rst_rd_count", rd_cnt, 896);
        chk("post_rst_done", int'(done_flag), 1);
        chk("post_rst_hazards", hazards, 0);

`ifdef KD_SEQ_HOLD_EN
        // Hold 10 cycles in the middle of layer 2
        do_run(1'b1, 1'b0, 300, 10, cyc);
        chk("hold_cycles", cyc, 1074);
        chk("hold_rd_count", rd_cnt, 1024);
        chk("hold_done", int'(done_flag), 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout want=finish");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
